// File: rtl/rtc_alarm_sched_if.sv
// Register-bus and interrupt bundle for rtc_alarm_sched.
// The master drives register accesses; the slave (scheduler) returns rdata and irq.
interface rtc_alarm_sched_if;
  logic        wr_en;
  logic        rd_en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  irq_id;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, irq, irq_id
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, irq, irq_id
  );
endinterface

// File: rtl/rtc_alarm_sched.sv
// Multi-channel RTC alarm scheduler: wrap-safe compare channels merged into one maskable irq.
// Define RTC_SCHED_PERIODIC_EN to add PERIOD registers and periodic reload; otherwise one-shot only.
module rtc_alarm_sched #(
  parameter int NUM_CH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      milisec,
  rtc_alarm_sched_if.slave bus
);

  localparam logic [4:0] A_ARM    = 5'h00;
  localparam logic [4:0] A_PEND   = 5'h01;
  localparam logic [4:0] A_MASK   = 5'h02;
  localparam logic [4:0] A_NOW    = 5'h03;
  localparam logic [4:0] A_CMP    = 5'h08;
`ifdef RTC_SCHED_PERIODIC_EN
  localparam logic [4:0] A_PERIOD = 5'h0C;
`endif

  logic [NUM_CH-1:0] arm_q, arm_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [31:0]       cmp_q [NUM_CH];
  logic [31:0]       cmp_d [NUM_CH];
`ifdef RTC_SCHED_PERIODIC_EN
  logic [31:0]       period_q [NUM_CH];
  logic [31:0]       period_d [NUM_CH];
`endif
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic [1:0]        irq_id_q, irq_id_d;
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] masked;

  // "Reached or passed": sign bit of the modulo difference, valid within 2^31 ms.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [31:0] diff;
    assign diff     = milisec - cmp_q[gi];
    assign fire[gi] = arm_q[gi] & ~diff[31];
  end

  // Register writes are applied after fire effects so software always wins a collision,
  // except PEND where a fire re-sets the bit after the W1C.
  always_comb begin
    arm_d  = arm_q;
    pend_d = pend_q | fire;
    mask_d = mask_q;
    cmp_d  = cmp_q;
`ifdef RTC_SCHED_PERIODIC_EN
    period_d = period_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (fire[c]) begin
`ifdef RTC_SCHED_PERIODIC_EN
        if (period_q[c] != 32'd0) begin
          cmp_d[c] = cmp_q[c] + period_q[c];
        end else begin
          arm_d[c] = 1'b0;
        end
`else
        arm_d[c] = 1'b0;
`endif
      end
    end
    if (bus.wr_en) begin
      case (bus.addr)
        A_ARM:   arm_d  = bus.wdata[NUM_CH-1:0];
        A_PEND:  pend_d = (pend_q & ~bus.wdata[NUM_CH-1:0]) | fire;
        A_MASK:  mask_d = bus.wdata[NUM_CH-1:0];
        default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.addr == A_CMP + 5'(c)) begin
          cmp_d[c] = bus.wdata;
        end
`ifdef RTC_SCHED_PERIODIC_EN
        if (bus.addr == A_PERIOD + 5'(c)) begin
          period_d[c] = bus.wdata;
        end
`endif
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (bus.rd_en) begin
      rdata_d = '0;
      case (bus.addr)
        A_ARM:   rdata_d = 32'(arm_q);
        A_PEND:  rdata_d = 32'(pend_q);
        A_MASK:  rdata_d = 32'(mask_q);
        A_NOW:   rdata_d = milisec;
        default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.addr == A_CMP + 5'(c)) begin
          rdata_d = cmp_q[c];
        end
`ifdef RTC_SCHED_PERIODIC_EN
        if (bus.addr == A_PERIOD + 5'(c)) begin
          rdata_d = period_q[c];
        end
`endif
      end
    end
  end

  // Downward scan leaves the lowest pending+enabled channel in irq_id.
  always_comb begin
    masked   = pend_q & mask_q;
    irq_d    = |masked;
    irq_id_d = 2'd0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (masked[c]) begin
        irq_id_d = 2'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q    <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= 2'd0;
      for (int c = 0; c < NUM_CH; c++) begin
        cmp_q[c] <= '0;
`ifdef RTC_SCHED_PERIODIC_EN
        period_q[c] <= '0;
`endif
      end
    end else begin
      arm_q    <= arm_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cmp_q[c] <= cmp_d[c];
`ifdef RTC_SCHED_PERIODIC_EN
        period_q[c] <= period_d[c];
`endif
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.irq    = irq_q;
  assign bus.irq_id = irq_id_q;

endmodule

// File: tb/tb_rtc_alarm_sched.sv
// Self-checking bench for rtc_alarm_sched: scoreboard queues of expected read data and irq state.
// Periodic checks run when RTC_SCHED_PERIODIC_EN is defined, one-shot config checks otherwise.
module tb_rtc_alarm_sched;

  localparam logic [4:0] A_ARM  = 5'h00;
  localparam logic [4:0] A_PEND = 5'h01;
  localparam logic [4:0] A_MASK = 5'h02;
  localparam logic [4:0] A_NOW  = 5'h03;
  localparam logic [4:0] A_CMP0 = 5'h08;
  localparam logic [4:0] A_CMP1 = 5'h09;
  localparam logic [4:0] A_CMP2 = 5'h0A;
  localparam logic [4:0] A_CMP3 = 5'h0B;
  localparam logic [4:0] A_PER0 = 5'h0C;
  localparam logic [4:0] A_PER1 = 5'h0D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] milisec = 32'd0;

  rtc_alarm_sched_if bus();

  rtc_alarm_sched #(.NUM_CH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .milisec (milisec),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd_exp_q[$];
  logic [2:0]  irq_exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    $display("wr   addr=%h data=%h ms=%0d", a, d, milisec);
  endtask

  // Expected value is queued when the read is issued and popped when rdata becomes valid.
  task automatic rd(input logic [4:0] a, input logic [31:0] e_in,
                    output logic [31:0] g, output logic [31:0] e);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    rd_exp_q.push_back(e_in);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    g = bus.rdata;
    e = rd_exp_q.pop_front();
    $display("rd   addr=%h data=%h expect=%h", a, g, e);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b000) begin
      errors++; $display("FAIL reset_irq: got=%b want=000", {bus.irq, bus.irq_id});
    end
    checks++;
    if (bus.rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: got=%h want=0", bus.rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rd(A_ARM, 32'd0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_arm: got=%h want=%h", got, exp); end
    rd(A_MASK, 32'd0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_mask: got=%h want=%h", got, exp); end
    rd(A_CMP2, 32'd0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_cmp2: got=%h want=%h", got, exp); end
    milisec = 32'd1234;
    rd(A_NOW, 32'd1234, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL now_read: got=%h want=%h", got, exp); end
    rd(5'h05, 32'd0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL unmapped_read: got=%h want=%h", got, exp); end
  endtask

  task automatic test_oneshot();
    milisec = 32'd95;
    wr(A_CMP0, 32'd100);
    wr(A_MASK, 32'h1);
    wr(A_ARM, 32'h1);
    for (int m = 96; m <= 99; m++) begin
      milisec = 32'(m);
      tick();
    end
    rd(A_PEND, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL oneshot_early: got=%h want=%h", got, exp); end
    milisec = 32'd100;
    tick();
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_latency: got=%b want=0", bus.irq); end
    tick();
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b100) begin
      errors++; $display("FAIL oneshot_irq: got=%b want=100", {bus.irq, bus.irq_id});
    end
    rd(A_ARM, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL oneshot_disarm: got=%h want=%h", got, exp); end
    rd(A_PEND, 32'h1, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL oneshot_pend: got=%h want=%h", got, exp); end
    wr(A_PEND, 32'h1);
    tick();
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL oneshot_w1c_irq: got=%b want=0", bus.irq); end
  endtask

  task automatic test_wrap();
    milisec = 32'hFFFF_FFF0;
    wr(A_CMP2, 32'h0000_0005);
    wr(A_MASK, 32'h4);
    wr(A_ARM, 32'h4);
    for (int i = 0; i < 20; i++) begin
      milisec = milisec + 32'd1;
      tick();
    end
    rd(A_PEND, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap_early: got=%h want=%h ms=%h", got, exp, milisec); end
    milisec = 32'h5;
    tick();
    rd(A_PEND, 32'h4, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap_fire: got=%h want=%h", got, exp); end
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b110) begin
      errors++; $display("FAIL wrap_irq: got=%b want=110", {bus.irq, bus.irq_id});
    end
    wr(A_PEND, 32'h4);
    wr(A_MASK, 32'h0);
  endtask

  task automatic test_priority();
    milisec = 32'd150;
    wr(A_CMP1, 32'd200);
    wr(A_CMP3, 32'd200);
    wr(A_MASK, 32'hA);
    wr(A_ARM, 32'hA);
    milisec = 32'd200;
    tick();
    tick();
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b101) begin
      errors++; $display("FAIL prio_id1: got=%b want=101", {bus.irq, bus.irq_id});
    end
    rd(A_PEND, 32'hA, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL prio_pend: got=%h want=%h", got, exp); end
    wr(A_PEND, 32'h2);
    tick();
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b111) begin
      errors++; $display("FAIL prio_id3: got=%b want=111", {bus.irq, bus.irq_id});
    end
    wr(A_PEND, 32'h8);
    tick();
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b000) begin
      errors++; $display("FAIL prio_clear: got=%b want=000", {bus.irq, bus.irq_id});
    end
  endtask

  task automatic test_collision();
    milisec = 32'd300;
    wr(A_CMP0, 32'd310);
    wr(A_MASK, 32'h1);
    wr(A_ARM, 32'h1);
    milisec = 32'd310;
    wr(A_PEND, 32'h1);
    rd(A_PEND, 32'h1, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_w1c_fire: got=%h want=%h", got, exp); end
    wr(A_PEND, 32'h1);
    rd(A_PEND, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_w1c_clear: got=%h want=%h", got, exp); end
    wr(A_CMP0, 32'd320);
    wr(A_ARM, 32'h1);
    milisec = 32'd320;
    wr(A_ARM, 32'h0);
    rd(A_ARM, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_arm_write: got=%h want=%h", got, exp); end
    rd(A_PEND, 32'h1, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_arm_pend: got=%h want=%h", got, exp); end
    wr(A_PEND, 32'h1);
    milisec = 32'd400;
    tick();
    tick();
    rd(A_PEND, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_no_refire: got=%h want=%h", got, exp); end
    wr(A_MASK, 32'h0);
  endtask

`ifdef RTC_SCHED_PERIODIC_EN
  task automatic test_periodic();
    logic [31:0] target;
    logic        pend_m;
    logic        fire_m;
    logic        w1c;
    int          last_fire;
    logic [2:0]  irq_g;
    logic [2:0]  irq_e;
    milisec = 32'd40;
    wr(A_CMP1, 32'd50);
    wr(A_PER1, 32'd20);
    wr(A_MASK, 32'h2);
    wr(A_ARM, 32'h2);
    target    = 32'd50;
    pend_m    = 1'b0;
    last_fire = -100;
    for (int m = 41; m <= 120; m++) begin
      w1c       = (m == last_fire + 3);
      bus.wr_en = w1c;
      bus.addr  = A_PEND;
      bus.wdata = 32'h2;
      milisec   = 32'(m);
      irq_exp_q.push_back(pend_m ? 3'b101 : 3'b000);
      fire_m = (32'(m) >= target);
      if (fire_m) begin
        target    = target + 32'd20;
        last_fire = m;
      end
      pend_m = (pend_m & ~w1c) | fire_m;
      tick();
      bus.wr_en = 1'b0;
      irq_g = {bus.irq, bus.irq_id};
      irq_e = irq_exp_q.pop_front();
      checks++;
      if (irq_g !== irq_e) begin
        errors++; $display("FAIL periodic_irq ms=%0d: got=%b want=%b", m, irq_g, irq_e);
      end
    end
    rd(A_CMP1, target, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL periodic_cmp: got=%0d want=%0d", got, exp); end
    rd(A_ARM, 32'h2, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL periodic_armed: got=%h want=%h", got, exp); end
    wr(A_ARM, 32'h0);
    wr(A_PEND, 32'h2);
    wr(A_MASK, 32'h0);
  endtask
`endif

  task automatic test_config();
`ifdef RTC_SCHED_PERIODIC_EN
    wr(A_PER0, 32'd10);
    rd(A_PER0, 32'd10, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL cfg_period_rw: got=%h want=%h", got, exp); end
    wr(A_PER0, 32'd0);
`else
    wr(A_PER0, 32'd10);
    rd(A_PER0, 32'd0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL cfg_period_absent: got=%h want=%h", got, exp); end
    milisec = 32'd500;
    wr(A_CMP0, 32'd505);
    wr(A_ARM, 32'h1);
    for (int m = 501; m <= 530; m++) begin
      milisec = 32'(m);
      tick();
    end
    rd(A_PEND, 32'h1, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL cfg_fire: got=%h want=%h", got, exp); end
    rd(A_ARM, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL cfg_oneshot_arm: got=%h want=%h", got, exp); end
    wr(A_PEND, 32'h1);
    milisec = 32'd540;
    tick();
    rd(A_PEND, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL cfg_fire_once: got=%h want=%h", got, exp); end
    rd(A_CMP0, 32'd505, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL cfg_no_reload: got=%0d want=%0d", got, exp); end
`endif
  endtask

  task automatic test_reset_mid();
    milisec = 32'd1000;
    wr(A_CMP0, 32'd900);
    wr(A_CMP1, 32'd900);
    wr(A_CMP2, 32'd900);
    wr(A_CMP3, 32'd900);
    wr(A_MASK, 32'hF);
    wr(A_ARM, 32'hF);
    tick();
    rd(A_PEND, 32'hF, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_pend_full: got=%h want=%h", got, exp); end
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b100) begin
      errors++; $display("FAIL mid_irq_before: got=%b want=100", {bus.irq, bus.irq_id});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.irq, bus.irq_id} !== 3'b000) begin
      errors++; $display("FAIL mid_irq_async: got=%b want=000", {bus.irq, bus.irq_id});
    end
    checks++;
    if (bus.rdata !== 32'd0) begin
      errors++; $display("FAIL mid_rdata_async: got=%h want=0", bus.rdata);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    rd(A_PEND, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_pend: got=%h want=%h", got, exp); end
    rd(A_ARM, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_arm: got=%h want=%h", got, exp); end
    rd(A_MASK, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_mask: got=%h want=%h", got, exp); end
    rd(A_CMP3, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_cmp3: got=%h want=%h", got, exp); end
    rd(A_PER1, 32'h0, got, exp); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_period1: got=%h want=%h", got, exp); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL mid_irq_after: got=%b want=0", bus.irq); end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = 5'd0;
    bus.wdata = 32'd0;
    test_reset();
    test_oneshot();
    test_wrap();
    test_priority();
    test_collision();
`ifdef RTC_SCHED_PERIODIC_EN
    test_periodic();
`endif
    test_config();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_alarm_sched.md
# rtc_alarm_sched

Multi-channel alarm scheduler driven by the RTC millisecond count (`milisec_reg`). Software configures up to four compare channels through a word-addressed register port. Each channel fires when the RTC count reaches its compare value, then either disarms (one-shot) or reloads itself (periodic). Pending events are merged into one maskable interrupt with a lowest-index priority channel ID, which lets the image-preprocessing firmware schedule frame timeouts and periodic tasks from a single RTC.

## Interface
Parameters:
- `NUM_CH`, default 4: number of alarm channels; legal range 1..4.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `milisec` in 32: current RTC millisecond count. It increments monotonically and wraps modulo 2^32.
- `wr_en` in 1: register write strobe, one cycle.
- `rd_en` in 1: register read strobe, one cycle.
- `addr` in 5: word address.
- `wdata` in 32: write data.
- `rdata` out 32: read data.
- `irq` out 1: interrupt, level-high. Equals OR of (pending & mask), registered.
- `irq_id` out 2: lowest-index channel with pending & mask set. It is 0 when `irq` is 0.

## Operation
Register map (word addresses):
- 0x00 ARM: bit c = channel c armed. Write sets or clears it directly.
- 0x01 PEND: bit c = channel c pending. Write 1 to clear.
- 0x02 MASK: bit c enables channel c onto `irq`.
- 0x03 NOW: read-only, returns `milisec`.
- 0x08+c CMP[c]: 32-bit compare value.
- 0x0C+c PERIOD[c]: 32-bit reload interval.
- Bits and addresses at or above `NUM_CH` read 0; writes to them are ignored. Unmapped addresses read 0.

Fire condition:
- Channel c fires when it is armed and `(milisec - CMP[c])` (32-bit, modulo) has bit 31 = 0.
- This is a wrap-safe "reached or passed" test, valid for targets within 2^31 ms.

On fire:
- PEND[c] is set.
- If PERIOD[c] != 0: CMP[c] becomes CMP[c] + PERIOD[c] (modulo 2^32) and the channel stays armed.
- If PERIOD[c] == 0: ARM[c] is cleared.
- Channels are evaluated independently. Several channels may fire in the same cycle.

Catch-up rule: if a periodic CMP lies behind `milisec` by more than one period, the channel fires on each consecutive cycle, adding PERIOD each time, until CMP is in the future. PEND stays set throughout.

## Timing
Reset values:
- ARM, PEND, MASK, CMP, PERIOD = 0.
- `rdata` = 0, `irq` = 0, `irq_id` = 0.

Fire latency:
- The fire condition is evaluated on the current `milisec` and current registers. PEND, CMP and ARM update at the same rising edge.
- `irq` and `irq_id` update one edge later (one registered stage from PEND).
- Total: `milisec` reaching CMP → `irq` high is 2 edges.

Register access:
- Writes take effect at the edge where `wr_en` is sampled.
- `rdata` is valid one cycle after `rd_en` and holds until the next read.

Simultaneous events:
- W1C to PEND[c] in the same cycle as a fire of c: the fire wins and PEND[c] stays 1.
- Write to ARM in the same cycle as a fire: the written ARM value wins. PEND is still set if the channel was armed before the edge.
- Write to CMP[c] or PERIOD[c] in the same cycle as a fire of c: the written value wins and the reload is discarded.

Other rules:
- Arming with CMP already passed (within 2^31) fires at the next edge.
- Reset asserted mid-operation clears all state immediately. No fire occurs until software re-arms.

## Configuration
- `RTC_SCHED_PERIODIC_EN` defined: periodic reload as above; PERIOD registers are present.
- Not defined:
  - PERIOD registers are not implemented: they read 0 and writes are ignored.
  - Every fire clears ARM[c], so all channels are one-shot.
  - All other behaviour is identical.

## Test plan
- **One-shot fire:** reset; write CMP0=100, MASK=1, ARM=1; ramp `milisec` from 95 → PEND=0x1 at the edge where `milisec`=100; `irq`=1, `irq_id`=0 one edge later; ARM reads 0x0.
- **Periodic reload** (macro defined): CMP1=50, PERIOD1=20, ARM=0x2, MASK=0x2; `milisec` sweeps 40..120 → fires at 50, 70, 90, 110; each W1C of 0x2 between fires drops `irq` one edge later.
- **Wrap-around:** CMP2=0x00000005, ARM=0x4; `milisec` steps 0xFFFFFFF0 → 0x5 → no fire before wrap; fires at 0x5.
- **Priority and simultaneous fire:** CMP1=CMP3=200, ARM=0xA, MASK=0xA; `milisec`=200 → PEND=0xA, `irq_id`=1; W1C 0x2 → `irq_id`=3; W1C 0x8 → `irq`=0.
- **Collision rules:** fire ch0 while writing PEND=0x1 in the same cycle → PEND bit0 remains 1. Write ARM=0 in the same cycle as the fire edge → ARM=0, PEND bit0 set, no later fire.
- **Reset mid-operation / config off:** assert `rst` low with PEND=0xF and `irq`=1 → `irq`, `rdata`, all registers read 0 immediately. With `RTC_SCHED_PERIODIC_EN` undefined, PERIOD0 write 10 reads back 0 and ch0 fires once only.
